// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: binary-to-BCD converter shared by two requesters.
// A round-robin arbiter accepts one operand at a time. The operand is then
// converted by an iterative double-dabble datapath, one operand bit per clock.
// Optional feature macro: BCD_ZERO_FAST_EN. When it is defined, a zero operand
// completes on the accept edge instead of running the shift sequence.
module bcd_conv_arbiter #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [BIN_W-1:0]      bin0,
    input  logic                  req1,
    input  logic [BIN_W-1:0]      bin1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  busy,
    output logic                  done,
    output logic                  owner,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               ptr;
    logic               cur;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_shift;
    logic               any_req;
    logic               sel;
    logic [BIN_W-1:0]   sel_bin;

    // Double-dabble correction: every digit above 4 gets +3, wrapping in 4 bits.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] a);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        r = a;
        for (int i = 0; i < DIGITS; i++) begin
            d = a[4*i +: 4];
            if (d > 4'd4) begin
                d = d + 4'd3;
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    // Arbitration: a lone request wins; on a tie the pointer decides.
    assign any_req   = req0 | req1;
    assign sel       = (req0 && req1) ? ptr : req1;
    assign sel_bin   = sel ? bin1 : bin0;

    // Correct the pre-shift digits, then shift the operand MSB into the units digit.
    assign acc_adj   = add3_digits(acc);
    assign acc_shift = {acc_adj[BCD_W-2:0], shreg[BIN_W-1]};

    assign busy      = (state == SHIFT);

    // Control FSM: accept/grant, bit counting, result capture and the rr pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 1'b0;
            cur   <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done  <= 1'b0;
            owner <= 1'b0;
            bcd   <= '0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt0 <= ~sel;
                        gnt1 <= sel;
                        ptr  <= ~sel;
                        cur  <= sel;
                        cnt  <= '0;
`ifdef BCD_ZERO_FAST_EN
                        if (sel_bin == '0) begin
                            done  <= 1'b1;
                            bcd   <= '0;
                            owner <= sel;
                        end else begin
                            state <= SHIFT;
                        end
`else
                        state <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        bcd   <= acc_shift;
                        owner <= cur;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers: loaded on accept, shifted every SHIFT cycle; no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            shreg <= sel_bin;
            acc   <= '0;
        end else if (state == SHIFT) begin
            shreg <= {shreg[BIN_W-2:0], 1'b0};
            acc   <= acc_shift;
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter (BIN_W = 8, DIGITS = 3).
module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [7:0]  bin0, bin1;
    logic        gnt0, gnt1, busy, done, owner;
    logic [11:0] bcd;

    int n_checks = 0;
    int n_pass   = 0;
    bit mptr     = 1'b0;   // reference round-robin pointer

`ifdef BCD_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    bcd_conv_arbiter #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .bin0(bin0),
        .req1(req1), .bin1(bin1),
        .gnt0(gnt0), .gnt1(gnt1),
        .busy(busy), .done(done),
        .owner(owner), .bcd(bcd)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got=%0d required=%0d checks", n_checks, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h required=%0h", name, got, exp);
    endtask

    // Reference: decimal digits computed arithmetically.
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference arbiter: lone request wins, tie goes to pointer, pointer moves past the winner.
    function automatic int model_pick(input bit r0, input bit r1);
        int s;
        s = (r0 && r1) ? int'(mptr) : (r1 ? 1 : 0);
        mptr = (s == 0);
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mptr = 1'b0;
    endtask

    // One transaction: raise the requests, wait for a grant, drop them, wait for done.
    // gsel: 0/1 granted requester, 2 both grants, -1 none. lat: cycles from gnt to done.
    task automatic do_conv(input bit r0, input bit r1, input logic [7:0] b0, input logic [7:0] b1,
                           output int gsel, output logic [11:0] rb, output logic ro,
                           output int lat, output logic busy_g);
        @(negedge clk);
        req0 = r0; req1 = r1; bin0 = b0; bin1 = b1;
        gsel = -1; lat = -1; rb = 'x; ro = 'x; busy_g = 'x;
        for (int c = 0; c < 20 && gsel < 0; c++) begin
            @(negedge clk);
            if (gnt0 && gnt1) gsel = 2;
            else if (gnt0)    gsel = 0;
            else if (gnt1)    gsel = 1;
        end
        busy_g = busy;
        req0 = 1'b0; req1 = 1'b0;
        if (gsel < 0) begin
            check("grant_timeout", 32'd0, 32'd1);
            return;
        end
        for (int c = 0; c <= 20; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
        rb = bcd; ro = owner;
    endtask

    typedef struct {
        bit          r0, r1;
        logic [7:0]  b0, b1;
        int          exp_gnt;
        logic [11:0] exp_bcd;
        logic        exp_owner;
    } vec_t;

    initial begin
        vec_t        vecs[7];
        int          gsel, lat, exp_lat, exp_s;
        logic [11:0] rb;
        logic        ro, bg;
        logic [7:0]  v, a, b;
        bit          r0, r1;

        vecs[0] = '{1, 0, 8'd255, 8'd0,   0, 12'h255, 1'b0};
        vecs[1] = '{0, 1, 8'd0,   8'd99,  1, 12'h099, 1'b1};
        vecs[2] = '{1, 1, 8'd10,  8'd200, 0, 12'h010, 1'b0};
        vecs[3] = '{1, 1, 8'd10,  8'd200, 1, 12'h200, 1'b1};
        vecs[4] = '{1, 0, 8'd0,   8'd77,  0, 12'h000, 1'b0};
        vecs[5] = '{0, 1, 8'd3,   8'd9,   1, 12'h009, 1'b1};
        vecs[6] = '{1, 1, 8'd100, 8'd7,   0, 12'h100, 1'b0};

        // Reset values
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
        #12;
        check("rst_gnt0",  32'(gnt0),  32'd0);
        check("rst_gnt1",  32'(gnt1),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_bcd",   32'(bcd),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_conv(vecs[i].r0, vecs[i].r1, vecs[i].b0, vecs[i].b1, gsel, rb, ro, lat, bg);
            v = (vecs[i].exp_gnt == 1) ? vecs[i].b1 : vecs[i].b0;
            exp_lat = (FAST && v == 0) ? 0 : 8;
            check($sformatf("tbl%0d_gnt", i),   32'(gsel), 32'(vecs[i].exp_gnt));
            check($sformatf("tbl%0d_bcd", i),   32'(rb),   32'(vecs[i].exp_bcd));
            check($sformatf("tbl%0d_owner", i), 32'(ro),   32'(vecs[i].exp_owner));
            check($sformatf("tbl%0d_lat", i),   32'(lat),  32'(exp_lat));
            check($sformatf("tbl%0d_busy", i),  32'(bg),   32'(exp_lat != 0));
        end

        // Both requests held continuously: alternating grants, 9-cycle done spacing
        do_reset();
        begin
            int gq[$];
            int dc[$];
            logic [11:0] dv[$];
            @(negedge clk);
            req0 = 1'b1; req1 = 1'b1; bin0 = 8'd10; bin1 = 8'd200;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (gnt0 && gnt1) check("hold_one_gnt", 32'd2, 32'd1);
                if (gnt0) gq.push_back(0);
                if (gnt1) gq.push_back(1);
                if (done) begin dc.push_back(c); dv.push_back(bcd); end
            end
            req0 = 1'b0; req1 = 1'b0;
            check("hold_ngnt", 32'(gq.size() >= 4), 32'd1);
            check("hold_ndone", 32'(dc.size() >= 3), 32'd1);
            if (gq.size() >= 4) begin
                for (int k = 0; k < 4; k++) check($sformatf("hold_gnt%0d", k), 32'(gq[k]), 32'(k % 2));
            end
            if (dc.size() >= 3) begin
                check("hold_space0", 32'(dc[1] - dc[0]), 32'd9);
                check("hold_space1", 32'(dc[2] - dc[1]), 32'd9);
                check("hold_res0", 32'(dv[0]), 32'h010);
                check("hold_res1", 32'(dv[1]), 32'h200);
                check("hold_res2", 32'(dv[2]), 32'h010);
            end
        end

        // Reset in the middle of a conversion
        do_reset();
        begin
            int g, nd;
            @(negedge clk);
            req0 = 1'b1; bin0 = 8'd128;
            g = 0;
            for (int c = 0; c < 20 && g == 0; c++) begin
                @(negedge clk);
                if (gnt0) g = 1;
            end
            req0 = 1'b0;
            check("midrst_gnt", 32'(g), 32'd1);
            repeat (3) @(negedge clk);
            rst = 1'b1;
            #1;
            check("midrst_busy",  32'(busy),  32'd0);
            check("midrst_done",  32'(done),  32'd0);
            check("midrst_gnt0",  32'(gnt0),  32'd0);
            check("midrst_gnt1",  32'(gnt1),  32'd0);
            check("midrst_owner", 32'(owner), 32'd0);
            check("midrst_bcd",   32'(bcd),   32'd0);
            @(negedge clk);
            rst = 1'b0;
            mptr = 1'b0;
            nd = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (done) nd++;
            end
            check("midrst_nodone", 32'(nd), 32'd0);
            exp_s = model_pick(1, 0);
            do_conv(1, 0, 8'd128, 8'd0, gsel, rb, ro, lat, bg);
            check("post_rst_gnt", 32'(gsel), 32'(exp_s));
            check("post_rst_bcd", 32'(rb),   32'h128);
            check("post_rst_own", 32'(ro),   32'd0);
        end

        // Exhaustive sweep through alternating requesters
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            r1 = (i % 2) == 1;
            exp_s = model_pick(!r1, r1);
            do_conv(!r1, r1, v, v, gsel, rb, ro, lat, bg);
            check($sformatf("sweep%0d_gnt", i),   32'(gsel), 32'(exp_s));
            check($sformatf("sweep%0d_bcd", i),   32'(rb),   32'(to_bcd(i)));
            check($sformatf("sweep%0d_owner", i), 32'(ro),   32'(exp_s));
        end

        // Randomized transactions against the reference model
        for (int i = 0; i < 60; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 9) == 0) a = 8'd0;
            exp_s = model_pick(r0, r1);
            v = (exp_s == 1) ? b : a;
            exp_lat = (FAST && v == 0) ? 0 : 8;
            do_conv(r0, r1, a, b, gsel, rb, ro, lat, bg);
            check($sformatf("rnd%0d_gnt", i),   32'(gsel), 32'(exp_s));
            check($sformatf("rnd%0d_bcd", i),   32'(rb),   32'(to_bcd(int'(v))));
            check($sformatf("rnd%0d_owner", i), 32'(ro),   32'(exp_s));
            check($sformatf("rnd%0d_lat", i),   32'(lat),  32'(exp_lat));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
